// File: rtl/mux_rr_arbiter_if.sv
// Purpose: bundles the request/grant/MUX-control signals between requesters, arbiter and the 8:1 MUX.
// Latency: none (wires only).
// Backpressure: none; requesters hold Request_In until granted, and the grant is their only flow control.
interface mux_rr_arbiter_if;
  logic [7:0] Request_In;
  logic [7:0] Grant_Out;
  logic [2:0] Select_Out;
  logic       Enable_Out;
  logic       Busy_Out;

  // Arbiter side: consumes requests, drives grant and MUX controls.
  modport slave (
    input  Request_In,
    output Grant_Out,
    output Select_Out,
    output Enable_Out,
    output Busy_Out
  );

  // Requester side: raises requests, observes grant and MUX controls.
  modport master (
    output Request_In,
    input  Grant_Out,
    input  Select_Out,
    input  Enable_Out,
    input  Busy_Out
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Purpose: round-robin arbiter granting one 8:1 MUX channel to eight requesters in bounded bursts.
// Latency: grant visible one edge after a request is sampled; optional GAP_CYCLES tri-state gap between bursts.
// Backpressure: a dropped request ends its burst at the next edge; other requests wait for the next arbitration.
module mux_rr_arbiter #(
  parameter int BURST_LEN  = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic            Clk_In,
  input  logic            Reset_N_In,
  mux_rr_arbiter_if.slave arb
);

  localparam logic [7:0] BURST_L = 8'(BURST_LEN);
  localparam logic [3:0] GAP_L   = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] sel_q, sel_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic [7:0] beat_q, beat_d;
  logic [3:0] gap_q, gap_d;
  logic [2:0] last_ptr_q, last_ptr_d;

  logic [7:0] req;
  logic [2:0] arb_base;
  logic [2:0] cand;
  logic [2:0] win_idx;
  logic       win_vld;
  logic       do_arb;

  assign req = arb.Request_In;

  // During GRANT the only arbitration that can happen is the zero-gap
  // back-to-back case, which must already see the current winner as last.
  assign arb_base = (state_q == ST_GRANT) ? sel_q : last_ptr_q;

  // Rotating priority search starting just above arb_base; arb_base itself is checked last.
  always_comb begin
    win_idx = 3'd0;
    win_vld = 1'b0;
    cand    = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      cand = arb_base + 3'(i);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    en_d       = en_q;
    beat_d     = beat_q;
    gap_d      = gap_q;
    last_ptr_d = last_ptr_q;
    do_arb     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          do_arb = 1'b1;
        end
      end

      ST_GRANT: begin
        // Burst limit and early release collapse into one end-of-grant path.
        if ((beat_q == BURST_L) || !req[sel_q]) begin
          last_ptr_d = sel_q;
          grant_d    = 8'h00;
          en_d       = 1'b0;
          beat_d     = 8'd0;
          if (GAP_L != 4'd0) begin
            state_d = ST_TURN;
            gap_d   = GAP_L;
          end else if (win_vld) begin
            do_arb = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          beat_d = beat_q + 8'd1;
        end
      end

      ST_TURN: begin
        if (gap_q == 4'd1) begin
          gap_d = 4'd0;
          if (win_vld) begin
            do_arb = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_arb) begin
      state_d = ST_GRANT;
      grant_d = 8'd1 << win_idx;
      sel_d   = win_idx;
      en_d    = 1'b1;
      beat_d  = 8'd1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; pointer resets to 7 so requester 0 leads after reset.
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_q    <= ST_IDLE;
      grant_q    <= 8'h00;
      sel_q      <= 3'd0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      beat_q     <= 8'd0;
      gap_q      <= 4'd0;
      last_ptr_q <= 3'd7;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      beat_q     <= beat_d;
      gap_q      <= gap_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  assign arb.Grant_Out  = grant_q;
  assign arb.Select_Out = sel_q;
  assign arb.Enable_Out = en_q;
  assign arb.Busy_Out   = busy_q;

  // Output invariants: grant at most one-hot, enable mirrors grant, select points at the grant.
  a_grant_onehot0: assert property (@(posedge Clk_In) disable iff (!Reset_N_In)
    $onehot0(grant_q));
  a_enable_matches: assert property (@(posedge Clk_In) disable iff (!Reset_N_In)
    en_q == (|grant_q));
  a_select_granted: assert property (@(posedge Clk_In) disable iff (!Reset_N_In)
    en_q |-> grant_q[sel_q]);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Purpose: self-checking bench for mux_rr_arbiter (BURST 4/GAP 1 and BURST 2/GAP 0 instances).
// Latency: outputs compared each falling edge against a queue of expected per-cycle values.
// Backpressure: request patterns are scripted per cycle, including early release and mid-grant reset.
module tb_mux_rr_arbiter;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] s;
    logic       en;
    logic       busy;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;

  mux_rr_arbiter_if arb_a ();
  mux_rr_arbiter_if arb_b ();

  mux_rr_arbiter #(.BURST_LEN(4), .GAP_CYCLES(1)) dut_a (
    .Clk_In     (clk),
    .Reset_N_In (rst_n),
    .arb        (arb_a)
  );

  mux_rr_arbiter #(.BURST_LEN(2), .GAP_CYCLES(0)) dut_b (
    .Clk_In     (clk),
    .Reset_N_In (rst_n),
    .arb        (arb_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  obs_t       exp_q[$];
  logic [7:0] stim_q[$];

  function automatic obs_t mk(input logic [7:0] g, input logic [2:0] s,
                              input logic en, input logic busy);
    obs_t r;
    r.g = g; r.s = s; r.en = en; r.busy = busy;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    arb_a.Request_In = 8'h00;
    arb_b.Request_In = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    arb_a.Request_In = 8'hFF;
    arb_b.Request_In = 8'hFF;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    o = {arb_a.Grant_Out, arb_a.Select_Out, arb_a.Enable_Out, arb_a.Busy_Out};
    n_checks++;
    if (o !== mk(8'h00, 3'd0, 1'b0, 1'b0))
      $display("FAIL reset_a got %h want %h", o, mk(8'h00, 3'd0, 1'b0, 1'b0));
    else n_pass++;
    o = {arb_b.Grant_Out, arb_b.Select_Out, arb_b.Enable_Out, arb_b.Busy_Out};
    n_checks++;
    if (o !== mk(8'h00, 3'd0, 1'b0, 1'b0))
      $display("FAIL reset_b got %h want %h", o, mk(8'h00, 3'd0, 1'b0, 1'b0));
    else n_pass++;
    arb_a.Request_In = 8'h00;
    arb_b.Request_In = 8'h00;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      o = {arb_a.Grant_Out, arb_a.Select_Out, arb_a.Enable_Out, arb_a.Busy_Out};
      n_checks++;
      if (o !== mk(8'h00, 3'd0, 1'b0, 1'b0))
        $display("FAIL idle_no_req cyc%0d got %h want %h", c, o, mk(8'h00, 3'd0, 1'b0, 1'b0));
      else n_pass++;
    end
  endtask

  task automatic test_single_requester();
    obs_t e, o;
    int c;
    do_reset();
    exp_q.delete(); stim_q.delete();
    for (int b = 0; b < 3; b++) begin
      repeat (4) exp_q.push_back(mk(8'h01, 3'd0, 1'b1, 1'b1));
      exp_q.push_back(mk(8'h00, 3'd0, 1'b0, 1'b1));
    end
    repeat (2) exp_q.push_back(mk(8'h00, 3'd0, 1'b0, 1'b0));
    repeat (13) stim_q.push_back(8'h01);
    stim_q.push_back(8'h00);
    arb_a.Request_In = 8'h01;
    c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = {arb_a.Grant_Out, arb_a.Select_Out, arb_a.Enable_Out, arb_a.Busy_Out};
      n_checks++;
      if (o !== e)
        $display("FAIL single cyc%0d got g=%h s=%0d en=%b busy=%b want g=%h s=%0d en=%b busy=%b",
                 c, o.g, o.s, o.en, o.busy, e.g, e.s, e.en, e.busy);
      else n_pass++;
      if (stim_q.size() > 0) arb_a.Request_In = stim_q.pop_front();
      c++;
    end
  endtask

  task automatic test_rotation();
    obs_t e, o;
    int c;
    do_reset();
    exp_q.delete(); stim_q.delete();
    for (int k = 0; k < 9; k++) begin
      repeat (4) exp_q.push_back(mk(8'd1 << (k % 8), 3'(k % 8), 1'b1, 1'b1));
      exp_q.push_back(mk(8'h00, 3'(k % 8), 1'b0, 1'b1));
    end
    arb_a.Request_In = 8'hFF;
    c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = {arb_a.Grant_Out, arb_a.Select_Out, arb_a.Enable_Out, arb_a.Busy_Out};
      n_checks++;
      if (o !== e)
        $display("FAIL rotation cyc%0d got g=%h s=%0d en=%b busy=%b want g=%h s=%0d en=%b busy=%b",
                 c, o.g, o.s, o.en, o.busy, e.g, e.s, e.en, e.busy);
      else n_pass++;
      if (stim_q.size() > 0) arb_a.Request_In = stim_q.pop_front();
      c++;
    end
  endtask

  task automatic test_pair_order();
    obs_t e, o;
    int c;
    do_reset();
    exp_q.delete(); stim_q.delete();
    repeat (4) exp_q.push_back(mk(8'h08, 3'd3, 1'b1, 1'b1));
    exp_q.push_back(mk(8'h00, 3'd3, 1'b0, 1'b1));
    repeat (4) exp_q.push_back(mk(8'h20, 3'd5, 1'b1, 1'b1));
    exp_q.push_back(mk(8'h00, 3'd5, 1'b0, 1'b1));
    repeat (4) exp_q.push_back(mk(8'h04, 3'd2, 1'b1, 1'b1));
    exp_q.push_back(mk(8'h00, 3'd2, 1'b0, 1'b1));
    repeat (4) exp_q.push_back(mk(8'h20, 3'd5, 1'b1, 1'b1));
    repeat (3) stim_q.push_back(8'h08);
    stim_q.push_back(8'h24);
    arb_a.Request_In = 8'h08;
    c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = {arb_a.Grant_Out, arb_a.Select_Out, arb_a.Enable_Out, arb_a.Busy_Out};
      n_checks++;
      if (o !== e)
        $display("FAIL pair_order cyc%0d got g=%h s=%0d en=%b busy=%b want g=%h s=%0d en=%b busy=%b",
                 c, o.g, o.s, o.en, o.busy, e.g, e.s, e.en, e.busy);
      else n_pass++;
      if (stim_q.size() > 0) arb_a.Request_In = stim_q.pop_front();
      c++;
    end
  endtask

  task automatic test_early_release();
    obs_t e, o;
    int c;
    do_reset();
    exp_q.delete(); stim_q.delete();
    // Two beats to requester 1, then pointer at 1 means 2 beats 0 in 8'h05.
    repeat (2) exp_q.push_back(mk(8'h02, 3'd1, 1'b1, 1'b1));
    exp_q.push_back(mk(8'h00, 3'd1, 1'b0, 1'b1));
    repeat (4) exp_q.push_back(mk(8'h04, 3'd2, 1'b1, 1'b1));
    exp_q.push_back(mk(8'h00, 3'd2, 1'b0, 1'b1));
    exp_q.push_back(mk(8'h01, 3'd0, 1'b1, 1'b1));
    stim_q.push_back(8'h02);
    stim_q.push_back(8'h05);
    arb_a.Request_In = 8'h02;
    c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = {arb_a.Grant_Out, arb_a.Select_Out, arb_a.Enable_Out, arb_a.Busy_Out};
      n_checks++;
      if (o !== e)
        $display("FAIL early_release cyc%0d got g=%h s=%0d en=%b busy=%b want g=%h s=%0d en=%b busy=%b",
                 c, o.g, o.s, o.en, o.busy, e.g, e.s, e.en, e.busy);
      else n_pass++;
      if (stim_q.size() > 0) arb_a.Request_In = stim_q.pop_front();
      c++;
    end
  endtask

  task automatic test_reset_mid_grant();
    obs_t e, o;
    int c;
    do_reset();
    exp_q.delete(); stim_q.delete();
    repeat (4) exp_q.push_back(mk(8'h01, 3'd0, 1'b1, 1'b1));
    exp_q.push_back(mk(8'h00, 3'd0, 1'b0, 1'b1));
    repeat (2) exp_q.push_back(mk(8'h80, 3'd7, 1'b1, 1'b1));
    repeat (3) stim_q.push_back(8'h01);
    stim_q.push_back(8'h81);
    arb_a.Request_In = 8'h01;
    c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = {arb_a.Grant_Out, arb_a.Select_Out, arb_a.Enable_Out, arb_a.Busy_Out};
      n_checks++;
      if (o !== e)
        $display("FAIL mid_reset_pre cyc%0d got g=%h s=%0d en=%b busy=%b want g=%h s=%0d en=%b busy=%b",
                 c, o.g, o.s, o.en, o.busy, e.g, e.s, e.en, e.busy);
      else n_pass++;
      if (stim_q.size() > 0) arb_a.Request_In = stim_q.pop_front();
      c++;
    end
    // Beat 2 of the grant to 7: reset must clear outputs without a clock edge.
    rst_n = 1'b0;
    #1;
    o = {arb_a.Grant_Out, arb_a.Select_Out, arb_a.Enable_Out, arb_a.Busy_Out};
    n_checks++;
    if (o !== mk(8'h00, 3'd0, 1'b0, 1'b0))
      $display("FAIL mid_reset_async got %h want %h", o, mk(8'h00, 3'd0, 1'b0, 1'b0));
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    o = {arb_a.Grant_Out, arb_a.Select_Out, arb_a.Enable_Out, arb_a.Busy_Out};
    n_checks++;
    if (o !== mk(8'h01, 3'd0, 1'b1, 1'b1))
      $display("FAIL mid_reset_restart got %h want %h", o, mk(8'h01, 3'd0, 1'b1, 1'b1));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    int c;
    do_reset();
    exp_q.delete(); stim_q.delete();
    for (int r = 0; r < 2; r++) begin
      repeat (2) exp_q.push_back(mk(8'h01, 3'd0, 1'b1, 1'b1));
      repeat (2) exp_q.push_back(mk(8'h02, 3'd1, 1'b1, 1'b1));
    end
    repeat (2) exp_q.push_back(mk(8'h00, 3'd1, 1'b0, 1'b0));
    repeat (7) stim_q.push_back(8'h03);
    stim_q.push_back(8'h00);
    arb_b.Request_In = 8'h03;
    c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = {arb_b.Grant_Out, arb_b.Select_Out, arb_b.Enable_Out, arb_b.Busy_Out};
      n_checks++;
      if (o !== e)
        $display("FAIL back_to_back cyc%0d got g=%h s=%0d en=%b busy=%b want g=%h s=%0d en=%b busy=%b",
                 c, o.g, o.s, o.en, o.busy, e.g, e.s, e.en, e.busy);
      else n_pass++;
      if (stim_q.size() > 0) arb_b.Request_In = stim_q.pop_front();
      c++;
    end
  endtask

  initial begin
    test_reset();
    test_single_requester();
    test_rotation();
    test_pair_order();
    test_early_release();
    test_reset_mid_grant();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
